// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between decode and a single-port request/grant data memory.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two word accesses; otherwise they error.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_sel,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT,
`ifdef LSU_MISALIGNED_EN
    S_REQ2, S_WAIT2,
`endif
    S_RESP
  } state_t;

  state_t            state_q;
  logic [3:0]        sel_q;
  logic [1:0]        off_q;
  logic              resp_valid_q, resp_err_q, mem_req_q, mem_we_q;
  logic [XLEN-1:0]   resp_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;

  logic              legal_d, bad_d;
  logic [7:0]        base_be_d, be_d;
  logic [XLEN-1:0]   wd_lo_d, shifted_d, rdata_d;
  logic [4:0]        sh_q;

  assign req_ready  = (state_q == S_IDLE);
  assign stall      = (state_q != S_IDLE) || req_valid;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign sh_q       = {off_q, 3'b000};

  // funct3[1:0] is the access size; loads also allow the unsigned byte/half forms.
  always_comb begin
    legal_d = (req_sel[2:1] != 2'b11) &&
              (req_sel[0] ? !(req_sel[3] && req_sel[2]) : !req_sel[3]);
    case (req_sel[2:1])
      2'b00:   base_be_d = 8'h01;
      2'b01:   base_be_d = 8'h03;
      default: base_be_d = 8'h0F;
    endcase
    be_d = base_be_d << req_addr[1:0];
  end

`ifdef LSU_MISALIGNED_EN
  logic              split_q;
  logic [3:0]        be_hi_q;
  logic [XLEN-1:0]   wd_hi_q, word1_q;
  logic [2*XLEN-1:0] wd64_d;
  assign wd64_d  = {{XLEN{1'b0}}, req_wdata} << {req_addr[1:0], 3'b000};
  assign wd_lo_d = wd64_d[XLEN-1:0];
  assign bad_d   = !legal_d;
`else
  assign wd_lo_d = req_wdata << {req_addr[1:0], 3'b000};
  assign bad_d   = !legal_d || (|be_d[7:4]);
`endif

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'b0, w[7:0]};
      3'b101:  extend = {16'b0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    shifted_d = mem_rdata >> sh_q;
`ifdef LSU_MISALIGNED_EN
    // low word of {second, first} >> sh; a split always has a nonzero offset
    if (state_q == S_WAIT2)
      shifted_d = (word1_q >> sh_q) | (mem_rdata << (6'd32 - {1'b0, sh_q}));
`endif
    rdata_d = extend(shifted_d, sel_q[3:1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      off_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
`ifdef LSU_MISALIGNED_EN
      split_q      <= 1'b0;
      be_hi_q      <= '0;
      wd_hi_q      <= '0;
      word1_q      <= '0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        S_IDLE: if (req_valid) begin
          sel_q <= req_sel;
          off_q <= req_addr[1:0];
          if (bad_d) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= !req_sel[0];
            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_q    <= be_d[3:0];
            mem_wdata_q <= wd_lo_d;
`ifdef LSU_MISALIGNED_EN
            split_q     <= |be_d[7:4];
            be_hi_q     <= be_d[7:4];
            wd_hi_q     <= wd64_d[2*XLEN-1:XLEN];
`endif
          end
        end
        S_REQ: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          if (sel_q[0]) begin
            state_q <= S_WAIT;
          end else
`ifdef LSU_MISALIGNED_EN
          if (split_q) begin
            state_q     <= S_REQ2;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
            mem_be_q    <= be_hi_q;
            mem_wdata_q <= wd_hi_q;
          end else
`endif
          begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end
        end
        S_WAIT: if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_EN
          if (split_q) begin
            word1_q    <= mem_rdata;
            state_q    <= S_REQ2;
            mem_req_q  <= 1'b1;
            mem_addr_q <= mem_addr_q + ADDR_W'(4);
            mem_be_q   <= be_hi_q;
          end else
`endif
          begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_d;
          end
        end
`ifdef LSU_MISALIGNED_EN
        S_REQ2: if (mem_gnt) begin
          mem_req_q <= 1'b0;
          if (sel_q[0]) begin
            state_q <= S_WAIT2;
          end else begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end
        end
        S_WAIT2: if (mem_rvalid) begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= rdata_d;
        end
`endif
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed vectors push expected responses, a monitor pops and compares.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_err, stall;
  logic [3:0]  req_sel, mem_be;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;

  lsu_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, expected no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk1($sformatf("resp%0d_err", mon_e.tag), resp_err, mon_e.err);
        chk($sformatf("resp%0d_rdata", mon_e.tag), resp_rdata, mon_e.rdata);
        chk($sformatf("resp%0d_cycle", mon_e.tag), cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string p);
    chk1({p, "_req_ready"}, req_ready, 1'b1);
    chk1({p, "_stall"}, stall, 1'b0);
    chk1({p, "_resp_valid"}, resp_valid, 1'b0);
    chk1({p, "_resp_err"}, resp_err, 1'b0);
    chk1({p, "_mem_req"}, mem_req, 1'b0);
    chk1({p, "_mem_we"}, mem_we, 1'b0);
    chk({p, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({p, "_mem_addr"}, mem_addr, 32'h0);
    chk({p, "_mem_be"}, {28'h0, mem_be}, 32'h0);
    chk({p, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // Presents a request in the current cycle (accept cycle n); returns at n+1 with req_valid low.
  task automatic issue(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] wd,
                       output int n);
    req_valid = 1'b1;
    req_sel   = sel;
    req_addr  = addr;
    req_wdata = wd;
    n         = cyc;
    smp();
    chk1("accept_req_ready", req_ready, 1'b1);
    chk1("accept_stall", stall, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_sel = '0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) smp();
    chk_idle("reset");
    tick();
    rst = 1'b0;
    tick();

    // LB at 0x1003, gnt with the request, rvalid next cycle
    issue(4'b0001, 32'h1003, 32'h0, n);
    sb.push_back('{1'b0, 32'hFFFFFF80, n + 3, 1});
    mem_gnt = 1'b1;
    smp();
    chk1("lb_mem_req", mem_req, 1'b1);
    chk1("lb_mem_we", mem_we, 1'b0);
    chk("lb_mem_addr", mem_addr, 32'h1000);
    chk("lb_mem_be", {28'h0, mem_be}, 32'h8);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80AABBCC;
    tick();
    mem_rvalid = 1'b0;
    smp();
    chk1("lb_stall_resp", stall, 1'b1);
    tick();
    smp();
    chk1("lb_stall_after", stall, 1'b0);
    tick();

    // SH at 0x2002 with grant held off three cycles
    issue(4'b0010, 32'h2002, 32'h0000BEEF, n);
    sb.push_back('{1'b0, 32'h0, n + 5, 2});
    for (int i = 0; i < 3; i++) begin
      smp();
      chk1("sh_mem_req", mem_req, 1'b1);
      chk1("sh_mem_we", mem_we, 1'b1);
      chk("sh_mem_addr", mem_addr, 32'h2000);
      chk("sh_mem_be", {28'h0, mem_be}, 32'hC);
      chk("sh_mem_wdata", mem_wdata, 32'hBEEF0000);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();

    // LHU at 0x10 followed by LW accepted directly after RESP
    issue(4'b1011, 32'h10, 32'h0, n);
    sb.push_back('{1'b0, 32'h0000F00D, n + 3, 3});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234F00D;
    tick();
    mem_rvalid = 1'b0;
    tick();
    issue(4'b0101, 32'h20, 32'h0, n);
    sb.push_back('{1'b0, 32'hCAFEBABE, n + 3, 4});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEBABE;
    tick();
    mem_rvalid = 1'b0;
    tick();
    tick();

    // illegal sel; a stray grant must be ignored
    issue(4'b0111, 32'h0, 32'h0, n);
    sb.push_back('{1'b1, 32'h0, n + 1, 5});
    mem_gnt = 1'b1;
    smp();
    chk1("ill_mem_req", mem_req, 1'b0);
    tick();
    mem_gnt = 1'b0;
    smp();
    chk1("ill_mem_req2", mem_req, 1'b0);
    tick();

    // misaligned LW at 0x101
    issue(4'b0101, 32'h101, 32'h0, n);
`ifdef LSU_MISALIGNED_EN
    sb.push_back('{1'b0, 32'h55443322, n + 5, 6});
    mem_gnt = 1'b1;
    smp();
    chk("mlw_addr1", mem_addr, 32'h100);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h44332211;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    smp();
    chk1("mlw_req2", mem_req, 1'b1);
    chk("mlw_addr2", mem_addr, 32'h104);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h88776655;
    tick();
    mem_rvalid = 1'b0;
    tick();
`else
    sb.push_back('{1'b1, 32'h0, n + 1, 6});
    smp();
    chk1("mlw_mem_req", mem_req, 1'b0);
    tick();
    tick();
`endif

    // misaligned SW at 0x1002
    issue(4'b0100, 32'h1002, 32'hAABBCCDD, n);
`ifdef LSU_MISALIGNED_EN
    sb.push_back('{1'b0, 32'h0, n + 3, 7});
    mem_gnt = 1'b1;
    smp();
    chk("msw_addr1", mem_addr, 32'h1000);
    chk("msw_be1", {28'h0, mem_be}, 32'hC);
    chk("msw_wdata1", mem_wdata, 32'hCCDD0000);
    tick();
    smp();
    chk1("msw_req2", mem_req, 1'b1);
    chk("msw_addr2", mem_addr, 32'h1004);
    chk("msw_be2", {28'h0, mem_be}, 32'h3);
    chk("msw_wdata2", mem_wdata, 32'h0000AABB);
    tick();
    mem_gnt = 1'b0;
    tick();
`else
    sb.push_back('{1'b1, 32'h0, n + 1, 7});
    smp();
    chk1("msw_mem_req", mem_req, 1'b0);
    tick();
    tick();
`endif

    // reset while waiting for read data, then a stale rvalid, then a clean LW
    issue(4'b0101, 32'h40, 32'h0, n);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    smp();
    chk_idle("midrst");
    tick();
    rst = 1'b0;
    smp();
    chk_idle("postrst");
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    smp();
    chk1("stale_req_ready", req_ready, 1'b1);
    tick();
    mem_rvalid = 1'b0;
    smp();
    chk1("stale_resp_valid", resp_valid, 1'b0);
    tick();
    issue(4'b0101, 32'h44, 32'h0, n);
    sb.push_back('{1'b0, 32'h13572468, n + 3, 8});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13572468;
    tick();
    mem_rvalid = 1'b0;
    repeat (4) tick();

    chk("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
